// File: rtl/default_slave_write_if.sv
// Handshake bundle for the default-slave write path: AW, W (control only) and B channels.
interface default_slave_write_if #(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned LEN_W = 4
);
  logic [ID_W-1:0]  AWID_SD;
  logic [LEN_W-1:0] AWLEN_SD;
  logic             AWVALID_SD;
  logic             AWREADY_SD;

  logic             WLAST_SD;
  logic             WVALID_SD;
  logic             WREADY_SD;

  logic [ID_W-1:0]  BID_SD;
  logic [1:0]       BRESP_SD;
  logic             BVALID_SD;
  logic             BREADY_SD;

  modport master (
    output AWID_SD, AWLEN_SD, AWVALID_SD, WLAST_SD, WVALID_SD, BREADY_SD,
    input  AWREADY_SD, WREADY_SD, BID_SD, BRESP_SD, BVALID_SD
  );

  modport slave (
    input  AWID_SD, AWLEN_SD, AWVALID_SD, WLAST_SD, WVALID_SD, BREADY_SD,
    output AWREADY_SD, WREADY_SD, BID_SD, BRESP_SD, BVALID_SD
  );
endinterface

// File: rtl/default_slave_write.sv
// Default slave for unmapped write addresses: swallows one burst and answers DECERR.
// Optional DSW_WLAST_CHECK_EN: end the burst on the AWLEN beat count and flag WLAST mismatches.
module default_slave_write #(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  default_slave_write_if.slave sd,
  output logic                 len_err
);

  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam logic [1:0]  DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [ID_W-1:0]   id_q,      id_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [CNT_W-1:0]  beat_q,    beat_d;
  logic              awready_q, awready_d;
  logic              wready_q,  wready_d;
  logic              bvalid_q,  bvalid_d;
  logic [ID_W-1:0]   bid_q,     bid_d;
  logic [1:0]        bresp_q,   bresp_d;

  logic              aw_hs_c;
  logic              w_hs_c;
  logic              b_hs_c;
  logic [CNT_W-1:0]  beat_inc_c;
  logic              last_c;

  assign aw_hs_c    = sd.AWVALID_SD & awready_q;
  assign w_hs_c     = sd.WVALID_SD  & wready_q;
  assign b_hs_c     = bvalid_q      & sd.BREADY_SD;
  assign beat_inc_c = beat_q + CNT_W'(1);

`ifdef DSW_WLAST_CHECK_EN
  logic at_len_c;
  logic len_err_q, len_err_d;

  // Counter is one bit wider than AWLEN so a full-length burst never wraps.
  assign at_len_c = (beat_inc_c == ({1'b0, len_q} + CNT_W'(1)));
  assign last_c   = at_len_c;

  // Sticky: any beat whose WLAST disagrees with the expected final beat.
  always_comb begin
    len_err_d = len_err_q;
    if (w_hs_c && (sd.WLAST_SD != at_len_c)) begin
      len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign last_c  = sd.WLAST_SD;
  assign len_err = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = 1'b0;
    bid_d     = '0;
    bresp_d   = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (aw_hs_c) begin
          id_d    = sd.AWID_SD;
          len_d   = sd.AWLEN_SD;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs_c) begin
          beat_d = beat_inc_c;
          if (last_c) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (b_hs_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are valid from the first cycle.
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
    if (state_d == RESP) begin
      bid_d   = id_d;
      bresp_d = DECERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign sd.AWREADY_SD = awready_q;
  assign sd.WREADY_SD  = wready_q;
  assign sd.BVALID_SD  = bvalid_q;
  assign sd.BID_SD     = bid_q;
  assign sd.BRESP_SD   = bresp_q;

endmodule

// File: doc/default_slave_write.md
DEFAULT_SLAVE_WRITE -- requirements
Module: default_slave_write

Interface
REQ-001 The block SHALL have parameter ID_W, default 8, giving the slave-side ID width (master ID plus master-select bits).
REQ-002 The block SHALL have parameter LEN_W, default 4, giving the AWLEN width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports AWID_SD (input, ID_W), AWLEN_SD (input, LEN_W), AWVALID_SD (input, 1) and AWREADY_SD (output, 1): the write-address channel for unmapped addresses.
REQ-006 The block SHALL have ports WLAST_SD (input, 1), WVALID_SD (input, 1) and WREADY_SD (output, 1): the write-data channel; data and strobe are not ported and are discarded.
REQ-007 The block SHALL have ports BID_SD (output, ID_W), BRESP_SD (output, 2), BVALID_SD (output, 1) and BREADY_SD (input, 1): the write-response channel into the downstream write-response mux, as slave 2.
REQ-008 The block SHALL have port len_err, output, 1 bit: sticky burst-length mismatch flag.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, DATA and RESP.
REQ-010 In IDLE: AWREADY_SD=1, WREADY_SD=0, BVALID_SD=0.
REQ-011 In IDLE, an AW handshake (AWVALID_SD & AWREADY_SD) SHALL latch AWID_SD into id_q and AWLEN_SD into len_q, clear the beat counter, and go to DATA next cycle.
REQ-012 In DATA: AWREADY_SD=0, WREADY_SD=1; every W handshake (WVALID_SD & WREADY_SD) SHALL increment the LEN_W+1-bit beat counter.
REQ-013 W beats presented while in IDLE or RESP SHALL NOT be accepted (WREADY_SD=0); the write-data channel is never accepted in the same cycle as the AW handshake.
REQ-014 Without DSW_WLAST_CHECK_EN, DATA SHALL exit to RESP on the W handshake carrying WLAST_SD=1, regardless of the beat count.
REQ-015 In RESP: BVALID_SD=1, BID_SD=id_q, BRESP_SD=2'b11 (DECERR), AWREADY_SD=0, WREADY_SD=0.
REQ-016 BID_SD and BRESP_SD SHALL remain stable while BVALID_SD=1 and BREADY_SD=0.
REQ-017 A B handshake (BVALID_SD & BREADY_SD) SHALL return the FSM to IDLE next cycle; a new AW SHALL be accepted no earlier than the cycle after.
REQ-018 Outside RESP, BID_SD=0 and BRESP_SD=2'b00.
REQ-019 The block SHALL hold one outstanding transaction only: one AW, then the full burst, then one B.
REQ-020 Latency SHALL be: AW handshake in cycle t, first W accept possible in t+1, BVALID_SD asserted the cycle after the final W handshake.
REQ-021 An AWLEN of 0 SHALL be a single-beat burst; AWLEN=2^LEN_W-1 (16 beats at default) SHALL be counted without counter wrap.

Reset
REQ-022 While rst=1, the FSM SHALL be IDLE; id_q, len_q and the beat counter 0; len_err 0; outputs AWREADY_SD=1, WREADY_SD=0, BVALID_SD=0, BID_SD=0, BRESP_SD=0.
REQ-023 Reset asserted mid-burst or during RESP SHALL abort the transaction immediately (asynchronously) with no B response issued.

Configuration
REQ-024 With macro DSW_WLAST_CHECK_EN defined, DATA SHALL exit to RESP on the W handshake that brings the beat count to len_q+1, ignoring WLAST_SD.
REQ-025 With DSW_WLAST_CHECK_EN defined, len_err SHALL set whenever WLAST_SD disagrees with (beat == len_q+1) on a W handshake, and SHALL clear only on reset.
REQ-026 Without DSW_WLAST_CHECK_EN, len_err SHALL be constant 0 and the behaviour SHALL follow REQ-014.

Verification
REQ-027 The bench SHALL cover this scenario: AWID=8'h23, AWLEN=0, one W beat with WLAST, BREADY=1 -> BVALID one cycle after the W handshake, BID=8'h23, BRESP=2'b11, then IDLE.
REQ-028 The bench SHALL cover this scenario: AWLEN=15, 16 beats with random WVALID gaps, WLAST on beat 16 -> exactly 16 W accepts, then one DECERR B.
REQ-029 The bench SHALL cover this scenario: B phase with BREADY held 0 for 5 cycles -> BVALID, BID and BRESP stable for all 5 cycles; AWREADY stays 0 until the cycle after the handshake.
REQ-030 The bench SHALL cover this scenario: WVALID=1 before AW arrives -> WREADY=0 until the cycle after the AW handshake.
REQ-031 The bench SHALL cover this scenario: rst pulsed during beat 3 of an AWLEN=7 burst -> outputs return immediately to reset values, no B issued, and the next AW is accepted normally.
REQ-032 The bench SHALL cover this scenario, with DSW_WLAST_CHECK_EN defined: AWLEN=3 with WLAST on beat 2 -> burst ends after beat 4, len_err=1 and stays 1 until reset.
